// File: rtl/popcount_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : popcount_rr_scheduler
// Purpose  : Shares one bit-population counter between NUM_REQ requesters.
//            A round-robin arbiter grants at most one request per cycle and
//            issues it to the counter. The winner's ID is queued in an
//            in-flight tag FIFO. Each counter result is broadcast on the
//            response bus, tagged with the ID at the FIFO head.
// Ports    : clk_i, srst_i          clock / synchronous active-high reset
//            req_valid_i/ready_o   per-requester handshake (ready one-hot)
//            req_data_i            requester i data at [i*WIDTH +: WIDTH]
//            pc_data_val_o/pc_data_o   issue side towards the counter
//            pc_data_val_i/pc_data_i   result side from the counter
//            resp_valid_o/id_o/data_o  tagged result, 1-cycle pulse
//            inflight_o            tag FIFO occupancy
//            err_o                 sticky: result arrived with no tag queued
// Revision : 1.0 - initial release
// ============================================================================
module popcount_rr_scheduler #(
    parameter int WIDTH        = 32,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int CNT_W = $clog2(WIDTH + 1) + 1,
    localparam int ID_W  = $clog2(NUM_REQ),
    localparam int PTR_W = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     pc_data_val_o,
    output logic [WIDTH-1:0]         pc_data_o,
    input  logic                     pc_data_val_i,
    input  logic [CNT_W-1:0]         pc_data_i,
    output logic                     resp_valid_o,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [CNT_W-1:0]         resp_data_o,
    output logic [PTR_W-1:0]         inflight_o,
    output logic                     err_o
);

    // Storage index width; pointers carry PTR_W bits but only address
    // MAX_INFLIGHT entries and wrap explicitly.
    localparam int IDX_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    localparam logic [PTR_W-1:0]   c_LAST_PTR = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [PTR_W-1:0]   c_FULL_CNT = PTR_W'(MAX_INFLIGHT);
    localparam logic [ID_W:0]      c_NREQ     = (ID_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    logic [ID_W-1:0]  r_rr_last;
    logic [ID_W-1:0]  r_tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_count;
    logic             r_pc_val;
    logic [WIDTH-1:0] r_pc_data;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [CNT_W-1:0] r_resp_data;
    logic             r_err;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W:0]        w_shift;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_off;
    logic [ID_W-1:0]      w_winner;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH-1:0]     w_win_data;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Round-robin search: rotate the valid vector so that bit 0 is the
    // requester right after the last winner, take the lowest set bit, then
    // map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        w_dbl   = {req_valid_i, req_valid_i};
        w_shift = {1'b0, r_rr_last} + 1'b1;
        w_rot   = NUM_REQ'(w_dbl >> w_shift);
        w_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
        w_sum = w_shift + {1'b0, w_off};
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_winner = w_sum[ID_W-1:0];
    end

    // A full FIFO blocks the grant even when a pop lands on the same edge:
    // there is no bypass path from the response side into the grant.
    assign w_push      = (|req_valid_i) && !w_full && !srst_i;
    assign req_ready_o = w_push ? (c_ONE << w_winner) : '0;
    assign w_win_data  = req_data_i[w_winner*WIDTH +: WIDTH];
    assign w_pop       = pc_data_val_i && !w_empty;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rr_last    <= ID_W'(NUM_REQ - 1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pc_val     <= 1'b0;
            r_pc_data    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_pc_val <= w_push;
            if (w_push) begin
                r_pc_data                     <= w_win_data;
                r_rr_last                     <= w_winner;
                r_tag_mem[r_wr_ptr[IDX_W-1:0]] <= w_winner;
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end

            r_resp_valid <= w_pop;
            if (w_pop) begin
                r_resp_data <= pc_data_i;
                r_resp_id   <= r_tag_mem[r_rd_ptr[IDX_W-1:0]];
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end

            // A result with no tag to pair it with is dropped and flagged.
            if (pc_data_val_i && w_empty) begin
                r_err <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pc_data_val_o = r_pc_val;
    assign pc_data_o     = r_pc_data;
    assign resp_valid_o  = r_resp_valid;
    assign resp_id_o     = r_resp_id;
    assign resp_data_o   = r_resp_data;
    assign inflight_o    = r_count;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_popcount_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_rr_scheduler
// Purpose  : Directed self-checking bench. Instance A (MAX_INFLIGHT=4, counter
//            latency 2) and instance B (MAX_INFLIGHT=2, latency 4) each drive
//            a behavioural popcount counter; scoreboards pair every tagged
//            response with the requester and data that was granted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_rr_scheduler;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int CW = 7;
    localparam int LA = 2;
    localparam int LB = 4;

    typedef struct packed {
        logic [1:0]    id;
        logic [CW-1:0] cnt;
    } tag_t;

    logic clk = 1'b0;
    logic srst;

    logic [NR-1:0]   a_valid, a_ready, b_valid, b_ready;
    logic [NR*W-1:0] a_data, b_data;
    logic            a_pc_val, b_pc_val;
    logic [W-1:0]    a_pc_data, b_pc_data;
    logic            a_cnt_val, b_cnt_val;
    logic [CW-1:0]   a_cnt_data, b_cnt_data;
    logic            a_resp_valid, b_resp_valid;
    logic [1:0]      a_resp_id, b_resp_id;
    logic [CW-1:0]   a_resp_data, b_resp_data;
    logic [2:0]      a_inflight;
    logic [1:0]      b_inflight;
    logic            a_err, b_err;

    logic            inj_val;
    logic [CW-1:0]   inj_data;

    logic [LA-1:0]   pa_v;
    logic [CW-1:0]   pa_d [LA];
    logic [LB-1:0]   pb_v;
    logic [CW-1:0]   pb_d [LB];

    tag_t qa[$];
    tag_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   b_resp_count = 0;

    always #5 clk = ~clk;

    popcount_rr_scheduler #(.WIDTH(W), .NUM_REQ(NR), .MAX_INFLIGHT(4)) u_dut_a (
        .clk_i(clk), .srst_i(srst),
        .req_valid_i(a_valid), .req_data_i(a_data), .req_ready_o(a_ready),
        .pc_data_val_o(a_pc_val), .pc_data_o(a_pc_data),
        .pc_data_val_i(a_cnt_val), .pc_data_i(a_cnt_data),
        .resp_valid_o(a_resp_valid), .resp_id_o(a_resp_id), .resp_data_o(a_resp_data),
        .inflight_o(a_inflight), .err_o(a_err)
    );

    popcount_rr_scheduler #(.WIDTH(W), .NUM_REQ(NR), .MAX_INFLIGHT(2)) u_dut_b (
        .clk_i(clk), .srst_i(srst),
        .req_valid_i(b_valid), .req_data_i(b_data), .req_ready_o(b_ready),
        .pc_data_val_o(b_pc_val), .pc_data_o(b_pc_data),
        .pc_data_val_i(b_cnt_val), .pc_data_i(b_cnt_data),
        .resp_valid_o(b_resp_valid), .resp_id_o(b_resp_id), .resp_data_o(b_resp_data),
        .inflight_o(b_inflight), .err_o(b_err)
    );

    // Behavioural fixed-latency counters, held in the same reset as the DUTs.
    always @(posedge clk) begin
        if (srst) begin
            pa_v <= '0;
            pb_v <= '0;
        end else begin
            pa_v     <= {pa_v[LA-2:0], a_pc_val};
            pa_d[0]  <= CW'($countones(a_pc_data));
            for (int k = 1; k < LA; k++) pa_d[k] <= pa_d[k-1];
            pb_v     <= {pb_v[LB-2:0], b_pc_val};
            pb_d[0]  <= CW'($countones(b_pc_data));
            for (int k = 1; k < LB; k++) pb_d[k] <= pb_d[k-1];
        end
    end

    assign a_cnt_val  = pa_v[LA-1] | inj_val;
    assign a_cnt_data = inj_val ? inj_data : pa_d[LA-1];
    assign b_cnt_val  = pb_v[LB-1];
    assign b_cnt_data = pb_d[LB-1];

    // Scoreboards: sampled mid-cycle, so a visible valid&ready completes on
    // the following posedge.
    always @(negedge clk) begin
        tag_t e;
        if (a_resp_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL sb_a: got id=%0d data=%0d, required no response", a_resp_id, a_resp_data);
            end else begin
                e = qa.pop_front();
                if ({a_resp_id, a_resp_data} !== e) begin
                    errors++;
                    $display("FAIL sb_a: got id=%0d data=%0d, required id=%0d data=%0d",
                             a_resp_id, a_resp_data, e.id, e.cnt);
                end
            end
        end
        if (b_resp_valid) begin
            checks++;
            b_resp_count++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL sb_b: got id=%0d data=%0d, required no response", b_resp_id, b_resp_data);
            end else begin
                e = qb.pop_front();
                if ({b_resp_id, b_resp_data} !== e) begin
                    errors++;
                    $display("FAIL sb_b: got id=%0d data=%0d, required id=%0d data=%0d",
                             b_resp_id, b_resp_data, e.id, e.cnt);
                end
            end
        end
        if (srst) begin
            qa.delete();
            qb.delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (a_valid[i] && a_ready[i]) qa.push_back({2'(i), CW'($countones(a_data[i*W +: W]))});
                if (b_valid[i] && b_ready[i]) qb.push_back({2'(i), CW'($countones(b_data[i*W +: W]))});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1; a_valid = '0; b_valid = '0; inj_val = 1'b0;
        step();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; a_valid = '0; b_valid = '0; inj_val = 1'b0; inj_data = '0;
        a_data = '0; b_data = '0;
        step();
        step();
        checks++;
        if ({a_pc_val, a_pc_data, a_resp_valid, a_resp_id, a_resp_data, a_inflight, a_err} !== '0) begin
            errors++;
            $display("FAIL reset_a_outputs: got pcv=%0b pcd=%0h rv=%0b id=%0d rd=%0d inf=%0d err=%0b, required all 0",
                     a_pc_val, a_pc_data, a_resp_valid, a_resp_id, a_resp_data, a_inflight, a_err);
        end
        checks++;
        if ({b_pc_val, b_resp_valid, b_inflight, b_err} !== '0) begin
            errors++;
            $display("FAIL reset_b_outputs: got pcv=%0b rv=%0b inf=%0d err=%0b, required all 0",
                     b_pc_val, b_resp_valid, b_inflight, b_err);
        end
        a_valid = 4'b1111; b_valid = 4'b1111;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ready_forced: got a=%b b=%b, required 0000 0000", a_ready, b_ready);
        end
        a_valid = '0; b_valid = '0;
        srst = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        a_data[31:0] = 32'h0000_00FF;
        a_valid = 4'b0001;
        #1;
        checks++;
        if (a_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b, required 0001", a_ready);
        end
        step();
        a_valid = '0;
        checks++;
        if ({a_pc_val, a_pc_data, a_inflight} !== {1'b1, 32'h0000_00FF, 3'd1}) begin
            errors++;
            $display("FAIL single_issue: got pcv=%0b pcd=%h inf=%0d, required pcv=1 pcd=000000ff inf=1",
                     a_pc_val, a_pc_data, a_inflight);
        end
        step();
        checks++;
        if ({a_pc_val, a_pc_data} !== {1'b0, 32'h0000_00FF}) begin
            errors++;
            $display("FAIL single_issue_hold: got pcv=%0b pcd=%h, required pcv=0 pcd=000000ff", a_pc_val, a_pc_data);
        end
        step();
        checks++;
        if (a_resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_resp: got %0b, required 0", a_resp_valid);
        end
        step();
        checks++;
        if ({a_resp_valid, a_resp_id, a_resp_data, a_inflight} !== {1'b1, 2'd0, 7'd8, 3'd0}) begin
            errors++;
            $display("FAIL single_resp: got rv=%0b id=%0d data=%0d inf=%0d, required rv=1 id=0 data=8 inf=0",
                     a_resp_valid, a_resp_id, a_resp_data, a_inflight);
        end
        step();
        checks++;
        if ({a_resp_valid, a_resp_data} !== {1'b0, 7'd8}) begin
            errors++;
            $display("FAIL single_resp_pulse: got rv=%0b data=%0d, required rv=0 data=8", a_resp_valid, a_resp_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_data = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
        a_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (a_ready !== 4'(1 << k)) begin
                errors++; $display("FAIL b2b_grant%0d: got %b, required %b", k, a_ready, 4'(1 << k));
            end
            step();
        end
        a_valid = '0;
        checks++;
        if ({a_resp_valid, a_resp_id, a_resp_data, a_inflight} !== {1'b1, 2'd0, 7'd1, 3'd3}) begin
            errors++;
            $display("FAIL b2b_resp0: got rv=%0b id=%0d data=%0d inf=%0d, required rv=1 id=0 data=1 inf=3",
                     a_resp_valid, a_resp_id, a_resp_data, a_inflight);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if ({a_resp_valid, a_resp_id, a_resp_data} !== {1'b1, 2'(k), 7'(k + 1)}) begin
                errors++;
                $display("FAIL b2b_resp%0d: got rv=%0b id=%0d data=%0d, required rv=1 id=%0d data=%0d",
                         k, a_resp_valid, a_resp_id, a_resp_data, k, k + 1);
            end
        end
        checks++;
        if (a_inflight !== 3'd0) begin
            errors++; $display("FAIL b2b_drained: got inflight=%0d, required 0", a_inflight);
        end
    endtask

    task automatic test_fairness();
        int wdt;
        do_reset();
        a_data = '0;
        a_data[2*W +: W] = 32'h0000_0F0F;
        a_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            wdt = $urandom_range(0, W);
            a_data[31:0] = (wdt == 0) ? 32'h0 : (32'hFFFF_FFFF >> (W - wdt));
            if (c == 5) a_valid = 4'b0101;
            #1;
            checks++;
            if (c < 5) begin
                if (a_ready !== 4'b0001) begin
                    errors++; $display("FAIL fair_solo%0d: got %b, required 0001", c, a_ready);
                end
            end else begin
                if (a_ready !== ((c % 2 == 1) ? 4'b0100 : 4'b0001)) begin
                    errors++;
                    $display("FAIL fair_alt%0d: got %b, required %b", c, a_ready,
                             (c % 2 == 1) ? 4'b0100 : 4'b0001);
                end
            end
            step();
        end
        a_valid = '0;
        repeat (5) step();
        checks++;
        if (a_inflight !== 3'd0) begin
            errors++; $display("FAIL fair_drained: got inflight=%0d, required 0", a_inflight);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        b_resp_count = 0;
        b_data = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
        b_valid = 4'b1111;
        #1;
        checks++;
        if (b_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_first_grant: got %b, required 0001", b_ready);
        end
        step();
        checks++;
        if ({b_ready, b_inflight} !== {4'b0010, 2'd1}) begin
            errors++; $display("FAIL bp_second_grant: got ready=%b inf=%0d, required 0010 inf=1", b_ready, b_inflight);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            checks++;
            if ({b_ready, b_inflight, b_resp_valid} !== {4'b0000, 2'd2, 1'b0}) begin
                errors++;
                $display("FAIL bp_full_e%0d: got ready=%b inf=%0d rv=%0b, required 0000 inf=2 rv=0",
                         c, b_ready, b_inflight, b_resp_valid);
            end
        end
        step();
        checks++;
        if ({b_resp_valid, b_resp_id, b_inflight, b_ready} !== {1'b1, 2'd0, 2'd1, 4'b0100}) begin
            errors++;
            $display("FAIL bp_resume: got rv=%0b id=%0d inf=%0d ready=%b, required rv=1 id=0 inf=1 ready=0100",
                     b_resp_valid, b_resp_id, b_inflight, b_ready);
        end
        step();
        checks++;
        if ({b_resp_valid, b_resp_id, b_inflight, b_ready} !== {1'b1, 2'd1, 2'd1, 4'b1000}) begin
            errors++;
            $display("FAIL bp_push_pop: got rv=%0b id=%0d inf=%0d ready=%b, required rv=1 id=1 inf=1 ready=1000",
                     b_resp_valid, b_resp_id, b_inflight, b_ready);
        end
        step();
        checks++;
        if ({b_inflight, b_ready} !== {2'd2, 4'b0000}) begin
            errors++; $display("FAIL bp_refull: got inf=%0d ready=%b, required inf=2 ready=0000", b_inflight, b_ready);
        end
        b_valid = '0;
        repeat (6) step();
        checks++;
        if ({b_inflight, b_err} !== {2'd0, 1'b0} || b_resp_count != 4) begin
            errors++;
            $display("FAIL bp_no_tag_lost: got inf=%0d err=%0b responses=%0d, required inf=0 err=0 responses=4",
                     b_inflight, b_err, b_resp_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_data = {32'hFFFF_0000, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h1111_1111};
        a_valid = 4'b1111;
        repeat (3) step();
        checks++;
        if (a_inflight !== 3'd3) begin
            errors++; $display("FAIL rmid_inflight: got %0d, required 3", a_inflight);
        end
        srst = 1'b1;
        #1;
        checks++;
        if (a_ready !== 4'b0000) begin
            errors++; $display("FAIL rmid_ready_forced: got %b, required 0000", a_ready);
        end
        step();
        srst = 1'b0;
        checks++;
        if ({a_pc_val, a_pc_data, a_resp_valid, a_inflight, a_err} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: got pcv=%0b pcd=%h rv=%0b inf=%0d err=%0b, required all 0",
                     a_pc_val, a_pc_data, a_resp_valid, a_inflight, a_err);
        end
        #1;
        checks++;
        if (a_ready !== 4'b0001) begin
            errors++; $display("FAIL rmid_next_grant: got %b, required 0001", a_ready);
        end
        step();
        a_valid = '0;
        repeat (4) step();
        checks++;
        if ({a_inflight, a_err} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL rmid_clean: got inf=%0d err=%0b, required inf=0 err=0", a_inflight, a_err);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        inj_val = 1'b1;
        inj_data = 7'd5;
        step();
        inj_val = 1'b0;
        checks++;
        if ({a_resp_valid, a_err, a_inflight} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL unexp_flag: got rv=%0b err=%0b inf=%0d, required rv=0 err=1 inf=0",
                     a_resp_valid, a_err, a_inflight);
        end
        repeat (3) step();
        checks++;
        if ({a_resp_valid, a_err} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL unexp_sticky: got rv=%0b err=%0b, required rv=0 err=1", a_resp_valid, a_err);
        end
        do_reset();
        checks++;
        if (a_err !== 1'b0) begin
            errors++; $display("FAIL unexp_clear: got err=%0b, required 0", a_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_unexpected();
        repeat (2) step();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got a=%0d b=%0d pending tags, required 0 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
